// File: rtl/sdf_bfly_if.sv
// Streaming sample bus for the SDF butterfly stage: indexed complex input
// samples in, indexed butterfly results out.
interface sdf_bfly_if #(
    parameter int DBW = 8,
    parameter int CBW = 3
);
    logic                  en;
    logic [CBW-1:0]        cnt;
    logic signed [DBW-1:0] din_re;
    logic signed [DBW-1:0] din_im;
    logic                  vout;
    logic [CBW-1:0]        cnt_out;
    logic signed [DBW:0]   dout_re;
    logic signed [DBW:0]   dout_im;

    modport master (
        output en, cnt, din_re, din_im,
        input  vout, cnt_out, dout_re, dout_im
    );

    modport slave (
        input  en, cnt, din_re, din_im,
        output vout, cnt_out, dout_re, dout_im
    );
endinterface

// File: rtl/sdf_bfly.sv
// Radix-2 single-path delay-feedback butterfly: sums leave during the second
// half of a frame, the matching differences during the next frame's first half.
module sdf_bfly #(
    parameter int DBW = 8,
    parameter int CBW = 3
) (
    input logic        clk,
    input logic        rst,
    sdf_bfly_if.slave  bus
);
    localparam int H = 1 << (CBW - 1);

    logic signed [DBW:0] mem_re [H];
    logic signed [DBW:0] mem_im [H];

    logic [CBW-2:0]      addr;
    logic                half;
    logic                primed;
    logic signed [DBW:0] ext_re, ext_im;
    logic signed [DBW:0] m_re, m_im;
    logic signed [DBW:0] sum_re, sum_im;
    logic signed [DBW:0] diff_re, diff_im;

    assign addr    = bus.cnt[CBW-2:0];
    assign half    = bus.cnt[CBW-1];
    assign ext_re  = {bus.din_re[DBW-1], bus.din_re};
    assign ext_im  = {bus.din_im[DBW-1], bus.din_im};
    assign m_re    = mem_re[addr];
    assign m_im    = mem_im[addr];
    assign sum_re  = m_re + ext_re;
    assign sum_im  = m_im + ext_im;
    assign diff_re = m_re - ext_re;
    assign diff_im = m_im - ext_im;

    // First half parks the raw sample; second half replaces it with the difference.
    always_ff @(posedge clk) begin
        if (bus.en) begin
            mem_re[addr] <= half ? diff_re : ext_re;
            mem_im[addr] <= half ? diff_im : ext_im;
        end
    end

    // primed keeps stale first-half memory contents from being flagged valid after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            primed      <= 1'b0;
            bus.vout    <= 1'b0;
            bus.cnt_out <= '0;
            bus.dout_re <= '0;
            bus.dout_im <= '0;
        end else if (bus.en) begin
            primed      <= primed | half;
            bus.vout    <= primed | half;
            bus.cnt_out <= {~half, addr};
            bus.dout_re <= half ? sum_re : m_re;
            bus.dout_im <= half ? sum_im : m_im;
        end else begin
            bus.vout    <= 1'b0;
        end
    end
endmodule
